output_port_scheduler: RTL and testbench

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

---
 rtl/output_port_scheduler_if.sv | 28 ++
 rtl/output_port_scheduler.sv | 136 +++++++++++++
 tb/tb_output_port_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/output_port_scheduler_if.sv
// Bundle of request, credit and grant signals between the input ports and
// the output port scheduler. The scheduler uses the slave modport and the
// requesting side uses the master modport.
interface output_port_scheduler_if #(
  parameter int N       = 5,
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [0:N-1]  i_req;
  logic [0:N-1]  i_tail;
  logic          i_credit_return;
  logic [0:N-1]  o_grant;
  logic          o_grant_valid;
  logic [CW-1:0] o_credits;
  logic          o_locked;
  logic          o_credit_err;

  modport master (
    output i_req, i_tail, i_credit_return,
    input  o_grant, o_grant_valid, o_credits, o_locked, o_credit_err
  );

  modport slave (
    input  i_req, i_tail, i_credit_return,
    output o_grant, o_grant_valid, o_credits, o_locked, o_credit_err
  );
endinterface

// File: rtl/output_port_scheduler.sv
// Output port scheduler: round-robin arbitration among N input ports with
// credit-based flow control toward a CREDITS-deep downstream buffer.
// Optional macro WORMHOLE_LOCK_EN: when defined, a granted non-tail flit
// locks the output to its input until that packet's tail is granted.
// When undefined, every flit is arbitrated independently and i_tail is ignored.
module output_port_scheduler #(
  parameter int N       = 5,
  parameter int CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  output_port_scheduler_if.slave   bus
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_n;
  logic [PW-1:0] owner, owner_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [CW-1:0] count;
  logic          err;

  logic          hit;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic [PW-1:0] sel;
  logic          take;
  logic [0:N-1]  grant;

  // Next index in round-robin order, wrapping N-1 back to 0.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] k);
    if (k == PW'(N - 1)) return '0;
    return k + PW'(1);
  endfunction

  // Credit count after one enabled cycle; a return at full capacity saturates.
  function automatic logic [CW-1:0] next_credits(input logic [CW-1:0] cnt,
                                                 input logic          ret,
                                                 input logic          used);
    case ({ret, used})
      2'b10:   return (cnt == CW'(CREDITS)) ? cnt : cnt + CW'(1);
      2'b01:   return cnt - CW'(1);
      default: return cnt;
    endcase
  endfunction

  // Round-robin scan: first requesting input starting at ptr.
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    cand = ptr;
    for (int j = 0; j < N; j++) begin
      if (!hit && bus.i_req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Grant decision: locked owner only, else the scan winner; none without credit.
  always_comb begin
    take  = 1'b0;
    sel   = win;
    grant = '0;
    if (ce && !reset && (count != '0)) begin
      if (state == LOCKED) begin
        if (bus.i_req[owner]) begin
          take = 1'b1;
          sel  = owner;
        end
      end else if (hit) begin
        take = 1'b1;
        sel  = win;
      end
    end
    if (take) grant[sel] = 1'b1;
  end

  // Next-state logic for lock state, owner and round-robin pointer.
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    if (take) begin
`ifdef WORMHOLE_LOCK_EN
      if (state == LOCKED) begin
        if (bus.i_tail[owner]) begin
          state_n = IDLE;
          ptr_n   = wrap_inc(owner);
        end
      end else if (!bus.i_tail[sel]) begin
        state_n = LOCKED;
        owner_n = sel;
      end else begin
        ptr_n = wrap_inc(sel);
      end
`else
      ptr_n = wrap_inc(sel);
`endif
    end
  end

  // State, credit counter and sticky error; everything holds while ce is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      count <= CW'(CREDITS);
      err   <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      count <= next_credits(count, bus.i_credit_return, take);
      err   <= err | (bus.i_credit_return & ~take & (count == CW'(CREDITS)));
    end
  end

`ifdef WORMHOLE_LOCK_EN
  assign bus.o_locked = (state == LOCKED);
`else
  logic unused_tail;
  assign unused_tail  = ^bus.i_tail;
  assign bus.o_locked = 1'b0;
`endif

  assign bus.o_grant       = grant;
  assign bus.o_grant_valid = take;
  assign bus.o_credits     = count;
  assign bus.o_credit_err  = err;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Testbench for output_port_scheduler: a table of directed vectors, hand
// sequences for locking and reset corner cases, and randomized traffic
// checked against a behavioural model of the arbitration and credit rules.
module tb_output_port_scheduler;
  localparam int N       = 5;
  localparam int CREDITS = 4;
`ifdef WORMHOLE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic ce;

  output_port_scheduler_if #(.N(N), .CREDITS(CREDITS)) bus ();

  output_port_scheduler #(.N(N), .CREDITS(CREDITS)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  int m_ptr;
  int m_owner;
  int m_cred;
  bit m_locked;
  bit m_err;

  // Values sampled by the last step
  logic [0:N-1] act_grant;
  int           act_cred;
  logic         act_locked;
  logic         act_err;

  typedef struct {
    logic [0:N-1] req;
    logic [0:N-1] tail;
    logic         ret;
    logic         c;
    logic [0:N-1] grant;
    int           cred;
    logic         err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int model_pick(input logic [0:N-1] r, input logic c);
    if (!c || m_cred == 0) return -1;
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int j = 0; j < N; j++)
      if (r[(m_ptr + j) % N]) return (m_ptr + j) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cred = CREDITS; m_locked = 0; m_err = 0;
  endtask

  // One cycle: drive at negedge, check against the model before the rising
  // edge, then advance the model by the rules of that edge.
  task automatic step(input logic [0:N-1] r, input logic [0:N-1] t,
                      input logic rt, input logic c);
    int g;
    logic [0:N-1] eg;
    @(negedge clk);
    bus.i_req = r; bus.i_tail = t; bus.i_credit_return = rt; ce = c;
    #1;
    g  = model_pick(r, c);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    act_grant  = bus.o_grant;
    act_cred   = int'(bus.o_credits);
    act_locked = bus.o_locked;
    act_err    = bus.o_credit_err;
    check("model_grant",   int'(act_grant), int'(eg));
    check("model_gvalid",  int'(bus.o_grant_valid), (g >= 0) ? 1 : 0);
    check("model_credits", act_cred, m_cred);
    check("model_locked",  int'(act_locked), int'(m_locked));
    check("model_err",     int'(act_err), int'(m_err));
    @(posedge clk);
    if (c) begin
      if (g >= 0) begin
        if (m_locked) begin
          if (t[g]) begin m_locked = 0; m_ptr = (g + 1) % N; end
        end else if (LOCK_EN && !t[g]) begin
          m_locked = 1; m_owner = g;
        end else begin
          m_ptr = (g + 1) % N;
        end
      end
      if (rt && g < 0) begin
        if (m_cred == CREDITS) m_err = 1;
        else m_cred++;
      end else if (!rt && g >= 0) begin
        m_cred--;
      end
    end
  endtask

  // Asynchronous reset mid-cycle; grant must stay low while reset is high.
  task automatic do_reset();
    @(negedge clk);
    bus.i_req = '1; bus.i_tail = '1; bus.i_credit_return = 1'b0; ce = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("grant_in_reset", int'(bus.o_grant), 0);
    check("gvalid_in_reset", int'(bus.o_grant_valid), 0);
    check("locked_in_reset", int'(bus.o_locked), 0);
    check("credits_in_reset", int'(bus.o_credits), CREDITS);
    check("err_in_reset", int'(bus.o_credit_err), 0);
    @(posedge clk);
    #1 check("grant_in_reset_edge", int'(bus.o_grant), 0);
    @(negedge clk);
    bus.i_req = '0; bus.i_tail = '0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic add(input logic [0:N-1] r, input logic rt, input logic c,
                     input logic [0:N-1] g, input int cr, input logic e);
    vec_t v;
    v.req = r; v.tail = '1; v.ret = rt; v.c = c; v.grant = g; v.cred = cr; v.err = e;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b0;
    bus.i_req = '0; bus.i_tail = '0; bus.i_credit_return = 1'b0;
    model_reset();

    // Directed vectors (all flits are tails): round-robin, credit exhaustion,
    // single-return regrant, ce hold, grant+return, saturation and sticky error.
    add(5'b10100, 1'b0, 1'b1, 5'b10000, 4, 1'b0);
    add(5'b10100, 1'b0, 1'b1, 5'b00100, 3, 1'b0);
    add(5'b10100, 1'b0, 1'b1, 5'b10000, 2, 1'b0);
    add(5'b10100, 1'b1, 1'b1, 5'b00100, 1, 1'b0);
    add(5'b11111, 1'b0, 1'b1, 5'b00010, 1, 1'b0);
    add(5'b11111, 1'b0, 1'b1, 5'b00000, 0, 1'b0);
    add(5'b11111, 1'b1, 1'b1, 5'b00000, 0, 1'b0);
    add(5'b11111, 1'b0, 1'b1, 5'b00001, 1, 1'b0);
    add(5'b00000, 1'b1, 1'b1, 5'b00000, 0, 1'b0);
    add(5'b11111, 1'b1, 1'b0, 5'b00000, 1, 1'b0);
    add(5'b11111, 1'b1, 1'b0, 5'b00000, 1, 1'b0);
    add(5'b11111, 1'b1, 1'b0, 5'b00000, 1, 1'b0);
    add(5'b00000, 1'b1, 1'b1, 5'b00000, 1, 1'b0);
    add(5'b10000, 1'b1, 1'b1, 5'b10000, 2, 1'b0);
    add(5'b00000, 1'b1, 1'b1, 5'b00000, 2, 1'b0);
    add(5'b00000, 1'b1, 1'b1, 5'b00000, 3, 1'b0);
    add(5'b00000, 1'b1, 1'b1, 5'b00000, 4, 1'b0);
    add(5'b00000, 1'b0, 1'b1, 5'b00000, 4, 1'b1);
    add(5'b11111, 1'b1, 1'b0, 5'b00000, 4, 1'b1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].tail, tbl[i].ret, tbl[i].c);
      check($sformatf("vec%0d_grant", i), int'(act_grant), int'(tbl[i].grant));
      check($sformatf("vec%0d_credits", i), act_cred, tbl[i].cred);
      check($sformatf("vec%0d_err", i), int'(act_err), int'(tbl[i].err));
      check($sformatf("vec%0d_locked", i), int'(act_locked), 0);
    end

`ifdef WORMHOLE_LOCK_EN
    // Input 1 sends a 3-flit packet while input 0 keeps requesting.
    do_reset();
    step(5'b10000, 5'b11111, 1'b0, 1'b1);
    check("pre_grant0", int'(act_grant), int'(5'b10000));
    step(5'b11000, 5'b00000, 1'b1, 1'b1);
    check("pkt_flit1", int'(act_grant), int'(5'b01000));
    step(5'b11000, 5'b00000, 1'b1, 1'b1);
    check("pkt_flit2", int'(act_grant), int'(5'b01000));
    check("pkt_locked2", int'(act_locked), 1);
    step(5'b11000, 5'b01000, 1'b1, 1'b1);
    check("pkt_flit3", int'(act_grant), int'(5'b01000));
    check("pkt_locked3", int'(act_locked), 1);
    step(5'b11000, 5'b10000, 1'b1, 1'b1);
    check("after_pkt_grant", int'(act_grant), int'(5'b10000));
    check("after_pkt_unlocked", int'(act_locked), 0);

    // Lock onto input 3, owner idle, then reset mid-packet.
    do_reset();
    step(5'b00010, 5'b00000, 1'b0, 1'b1);
    check("lock3_grant", int'(act_grant), int'(5'b00010));
    step(5'b10000, 5'b11111, 1'b0, 1'b1);
    check("owner_idle_nogrant", int'(act_grant), 0);
    check("owner_idle_locked", int'(act_locked), 1);
    do_reset();
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    check("post_reset_unlocked", int'(act_locked), 0);
    check("post_reset_credits", act_cred, CREDITS);
    step(5'b11111, 5'b11111, 1'b0, 1'b1);
    check("post_reset_ptr0", int'(act_grant), int'(5'b10000));
`else
    // Non-tail flits never lock the output.
    do_reset();
    step(5'b01000, 5'b00000, 1'b0, 1'b1);
    check("nolock_grant1", int'(act_grant), int'(5'b01000));
    step(5'b11000, 5'b00000, 1'b0, 1'b1);
    check("nolock_locked", int'(act_locked), 0);
    check("nolock_grant0", int'(act_grant), int'(5'b10000));
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [0:N-1] r, t;
      logic rt, c;
      r  = N'($urandom);
      t  = N'($urandom | $urandom);
      rt = ($urandom_range(0, 9) < 4);
      c  = ($urandom_range(0, 9) != 0);
      step(r, t, rt, c);
      if (i == 200) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
